// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller around an external dual-port RAM with a first-word-fall-through output stage
module ram_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int LG_DEPTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [LG_DEPTH+1:0]   count,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [LG_DEPTH-1:0]   ram_addra,
  output logic [WIDTH-1:0]      ram_dina,
  output logic                  ram_enb,
  output logic [LG_DEPTH-1:0]   ram_addrb,
  input  logic [WIDTH-1:0]      ram_doutb
);

  localparam logic [LG_DEPTH:0] RAM_FULL = (LG_DEPTH+1)'(DEPTH);

  logic [LG_DEPTH-1:0] wr_ptr;
  logic [LG_DEPTH-1:0] rd_ptr;
  logic [LG_DEPTH:0]   ram_cnt;
  logic                rd_pend;
  logic                skid_valid;
  logic [WIDTH-1:0]    skid_data;
  logic                wr;
  logic                rd;
  logic                pop;
  logic [1:0]          stage_cnt;

  // Handshakes, read credit and RAM port drive; reads are only issued when
  // the output stage (out + skid + word in flight) has room after this pop.
  always_comb begin
    pop       = out_valid && out_ready;
    in_ready  = !rst && (ram_cnt < RAM_FULL);
    wr        = in_valid && in_ready;
    stage_cnt = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pend};
    rd        = !rst && (ram_cnt != '0) && ((stage_cnt - {1'b0, pop}) < 2'd2);
    ram_ena   = wr;
    ram_wea   = wr;
    ram_addra = wr_ptr;
    ram_dina  = in_data;
    ram_enb   = rd;
    ram_addrb = rd_ptr;
  end

  // RAM pointers and occupancy; a simultaneous write and read leave ram_cnt unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd;
      if (wr) wr_ptr <= wr_ptr + LG_DEPTH'(1);
      if (rd) rd_ptr <= rd_ptr + LG_DEPTH'(1);
      case ({wr, rd})
        2'b10:   ram_cnt <= ram_cnt + (LG_DEPTH+1)'(1);
        2'b01:   ram_cnt <= ram_cnt - (LG_DEPTH+1)'(1);
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

  // Total word count tracks accepted writes minus pops, which equals the sum
  // of RAM occupancy, the in-flight read and both output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr, pop})
        2'b10:   count <= count + (LG_DEPTH+2)'(1);
        2'b01:   count <= count - (LG_DEPTH+2)'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register plus skid: skid feeds out first to keep order, returning
  // RAM data lands in out when it frees up, otherwise parks in skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        if (rd_pend) skid_data  <= ram_doutb;
        else         skid_valid <= 1'b0;
      end else if (rd_pend) begin
        out_valid <= 1'b1;
        out_data  <= ram_doutb;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (rd_pend) begin
      skid_valid <= 1'b1;
      skid_data  <= ram_doutb;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - self-checking bench for ram_fifo_ctrl
module tb_ram_fifo_ctrl;
  localparam int W  = 8;
  localparam int D  = 64;
  localparam int LG = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [LG+1:0] count;
  logic          ram_ena, ram_wea, ram_enb;
  logic [LG-1:0] ram_addra, ram_addrb;
  logic [W-1:0]  ram_dina;
  logic [W-1:0]  ram_doutb = '0;
  logic [W-1:0]  mem [D];

  ram_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .LG_DEPTH(LG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  // behavioural dual-port RAM with one-cycle synchronous read
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: words accepted into the FIFO, popped in order
  logic [W-1:0] q[$];
  int           sent = 0;
  int           popped = 0;
  bit           mon_en = 1'b0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] data_prev = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count_model", count, q.size());
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, data_prev);
      end
      if (out_valid && out_ready) begin
        chk("pop_data", out_data, (q.size() != 0) ? q.pop_front() : 32'hxxxxxxxx);
        popped++;
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(in_data);
      sent++;
    end
    stall_prev = mon_en && out_valid && !out_ready;
    data_prev  = out_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       eov;
    logic [7:0] eod;
    logic [7:0] ecnt;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 8'd1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd1};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 8'd1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0};
    tbl[4] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'd1};
    tbl[5] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 8'd2};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 8'd2};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 8'd2};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 8'd1};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0};

    // reset state, with a write offered during reset
    in_valid = 1'b1;
    tick();
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ram_ena", ram_ena, 0);
    chk("rst_ram_enb", ram_enb, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // single word latency and skid fill/drain
    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].eov);
      chk($sformatf("vec%0d_count", i), count, tbl[i].ecnt);
      if (tbl[i].eov) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].eod);
    end

    // fill to full with output stalled
    q.delete();
    sent = 0;
    popped = 0;
    mon_en = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (70) begin
      in_data = sent[7:0];
      tick();
    end
    chk("fill_count", count, 66);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_sent", sent, 66);

    // full: pop frees a RAM slot, next cycle write and read coincide
    out_ready = 1'b1;
    in_data = sent[7:0];
    #2;
    chk("full_ram_enb", ram_enb, 1);
    chk("full_in_ready", in_ready, 0);
    tick();
    in_data = sent[7:0];
    #2;
    chk("simul_in_ready", in_ready, 1);
    chk("simul_ram_ena", ram_ena, 1);
    chk("simul_ram_enb", ram_enb, 1);
    tick();
    in_valid = 1'b0;
    repeat (80) tick();
    chk("drain_popped", popped, 67);
    chk("drain_count", count, 0);

    // continuous streaming across pointer wrap
    sent = 0;
    popped = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      in_data = k[7:0];
      #2;
      chk($sformatf("stream_out_valid%0d", k), out_valid, (k >= 3) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("stream_sent", sent, 200);
    chk("stream_popped", popped, 200);
    chk("stream_count", count, 0);

    // random backpressure
    sent = 0;
    popped = 0;
    for (int c = 0; c < 3000 && popped < 500; c++) begin
      out_ready = 1'($urandom % 2);
      in_valid  = (sent < 500);
      in_data   = sent[7:0];
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_sent", sent, 500);
    chk("bp_popped", popped, 500);
    chk("bp_count", count, 0);

    // reset mid-stream with a read in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (10) begin
      in_data = sent[7:0];
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", count, 10);
    mon_en = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("pre_rst_ram_enb", ram_enb, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ram_enb", ram_enb, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    q.delete();
    sent = 0;
    popped = 0;
    mon_en = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && popped < 1; c++) tick();
    chk("after_rst_popped", popped, 1);
    chk("after_rst_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
